// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
// The fetch entry type describes the {pc, inst} pair held in the prefetch queue.
package ifu_pkg;
    localparam int INST_BYTES = 4;
    localparam int XLEN_DEF = 32;
    localparam int ILEN_DEF = 32;
    localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/ifu_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; head data is read straight from storage.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifu_sync_fifo
    import ifu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & ~empty;
    // a push into a full queue is allowed when the head leaves in the same cycle
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: sequential fetch with credit-limited issue, in-order
// response pairing via a PC tag queue, and redirect flush with stale-response discard.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter int              ILEN            = 32,
    parameter int              DEPTH           = 4,
    parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEF),
    parameter int              MAX_OUTSTANDING = DEPTH
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_code,
    output logic [XLEN-1:0] inst_pc,
    output logic            busy
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = XLEN + ILEN;

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   out_cnt;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   entry_count;
    logic [CW-1:0]   tag_count;
    logic            entry_full;
    logic            entry_empty;
    logic            tag_full;
    logic            tag_empty;
    logic [EW-1:0]   head;
    logic [XLEN-1:0] tag_pc;
    logic [CW:0]     credit_used;
    logic            issue;
    logic            rsp_keep;
    logic            pop;

    // queued entries plus everything in flight (stale or not) must fit in the queue
    assign credit_used    = (CW+1)'(entry_count) + (CW+1)'(out_cnt);
    assign imem_req_valid = !reset && !redirect_valid
                            && (credit_used < (CW+1)'(DEPTH))
                            && (out_cnt < CW'(MAX_OUTSTANDING));
    assign imem_req_addr  = fetch_pc;
    assign issue          = imem_req_valid & imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (discard == '0);

    assign inst_valid = !entry_empty;
    assign pop        = inst_valid & inst_ready;
    assign inst_pc    = inst_valid ? head[EW-1 -: XLEN] : '0;
    assign inst_code  = inst_valid ? head[ILEN-1:0] : '0;
    assign busy       = (out_cnt != '0) || inst_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            out_cnt  <= '0;
            discard  <= '0;
        end else begin
            out_cnt <= out_cnt + CW'(issue) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~XLEN'(3);
                discard  <= out_cnt - CW'(imem_rsp_valid);
            end else begin
                if (issue) fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
                if (imem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
            end
        end
    end

    ifu_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_entry_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data ({tag_pc, imem_rsp_data}),
        .pop       (pop),
        .pop_data  (head),
        .count     (entry_count),
        .full      (entry_full),
        .empty     (entry_empty)
    );

    // tags of discarded responses were already cleared by the redirect, so only kept responses pop
    ifu_sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (issue),
        .push_data (fetch_pc),
        .pop       (rsp_keep),
        .pop_data  (tag_pc),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    assert property (@(posedge clock) disable iff (reset) !(imem_rsp_valid && entry_full));
    assert property (@(posedge clock) disable iff (reset) tag_count == (out_cnt - discard));
    assert property (@(posedge clock) disable iff (reset) !(rsp_keep && tag_empty));
    assert property (@(posedge clock) disable iff (reset) !(issue && tag_full));
endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: a memory model answers requests in order with random
// latency, accepted fetches queue their expected {pc, code}, and a monitor checks deliveries.
module tb_ifu_prefetch;
    logic        clock;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_code;
    logic [31:0] inst_pc;
    logic        busy;

    ifu_prefetch dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_code      (inst_code),
        .inst_pc        (inst_pc),
        .busy           (busy)
    );

    typedef struct { int due; logic [31:0] addr; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] code; } exp_t;

    pend_t pend_q[$];
    exp_t  exp_q[$];

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          deliv_cnt = 0;
    int          first_acc = -1;
    int          first_val = -1;
    int          last_due = 0;
    int unsigned rdy_pct = 100;
    int unsigned ird_pct = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    logic        redir_req = 0;
    logic [31:0] redir_target = '0;
    logic [31:0] model_pc = '0;
    logic        was_redirect = 0;
    logic        saw_wrap = 0;
    logic [31:0] prev_pc = '0;

    function automatic logic [31:0] code_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1 ^ (a << 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    // memory model and stimulus: inputs change on the falling edge, sampled 1 time unit later
    initial begin : driver
        int due;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                imem_rsp_valid = 0;
                imem_rsp_data  = '0;
                redirect_valid = 0;
                redirect_pc    = '0;
                imem_req_ready = 0;
                inst_ready     = 0;
                pend_q.delete();
                exp_q.delete();
                model_pc     = 32'h0;
                last_due     = 0;
                was_redirect = 0;
                acc_cnt      = 0;
                first_acc    = -1;
                first_val    = -1;
                continue;
            end
            imem_rsp_valid = 0;
            if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                imem_rsp_valid = 1;
                imem_rsp_data  = code_of(pend_q[0].addr);
                void'(pend_q.pop_front());
            end
            redirect_valid = redir_req;
            redirect_pc    = redir_target;
            redir_req      = 0;
            imem_req_ready = ($urandom_range(99) < rdy_pct);
            inst_ready     = ($urandom_range(99) < ird_pct);
            #1;
            if (was_redirect) chk("inst_valid_after_redirect", 32'(inst_valid), 32'd0);
            if (redirect_valid) chk("req_valid_during_redirect", 32'(imem_req_valid), 32'd0);
            if (inst_valid && first_val < 0) first_val = cyc;
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, model_pc);
                exp_q.push_back('{model_pc, code_of(model_pc)});
                chk("credit_limit", 32'(exp_q.size() <= 4), 32'd1);
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend_q.push_back('{due, imem_req_addr});
                model_pc = model_pc + 32'd4;
                acc_cnt++;
                if (first_acc < 0) first_acc = cyc;
            end
            was_redirect = redirect_valid;
            #2;
            // a redirect kills every fetch that decode has not consumed yet
            if (redirect_valid) begin
                exp_q.delete();
                model_pc = redirect_pc & ~32'd3;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (!reset && inst_valid && inst_ready) begin
                deliv_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_inst: pc %h delivered, nothing expected", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst_pc", inst_pc, e.pc);
                    chk("inst_code", inst_code, e.code);
                    if (e.pc == 32'h0 && prev_pc == 32'hFFFF_FFFC) saw_wrap = 1;
                    prev_pc = e.pc;
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
        #4;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #4 reset = 1;
        repeat (2) @(negedge clock);
        #4 reset = 0;
    endtask

    initial begin : main
        int d0;
        int a0;
        int n;
        reset = 0;
        redirect_valid = 0;
        redirect_pc = '0;
        imem_req_ready = 0;
        imem_rsp_valid = 0;
        imem_rsp_data = '0;
        inst_ready = 0;
        #1 reset = 1;
        #1;
        chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
        chk("reset_req_addr", imem_req_addr, 32'h0);
        chk("reset_inst_valid", 32'(inst_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clock);
        #4 reset = 0;

        // streaming with 1-cycle memory: latency and throughput
        wait_cyc(12);
        chk("first_valid_latency", 32'(first_val - first_acc), 32'd2);
        d0 = deliv_cnt;
        wait_cyc(20);
        chk("stream_throughput", 32'(deliv_cnt - d0), 32'd20);

        // decode stalled: exactly DEPTH requests, then resume
        ird_pct = 0;
        do_reset();
        wait_cyc(15);
        chk("stall_accept_count", 32'(acc_cnt), 32'd4);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        ird_pct = 100;
        d0 = deliv_cnt;
        wait_cyc(20);
        chk("resume_throughput", 32'(deliv_cnt - d0), 32'd20);

        // redirect with three requests in flight
        ird_pct = 0;
        lat_min = 5;
        lat_max = 5;
        do_reset();
        wait_cyc(3);
        chk("inflight_before_redirect", 32'(acc_cnt), 32'd3);
        redir_req = 1;
        redir_target = 32'h0000_0103;
        ird_pct = 100;
        d0 = deliv_cnt;
        wait_cyc(25);
        chk("redirect_progress", 32'(deliv_cnt - d0 >= 5), 32'd1);

        // redirect together with a response and a pop while two entries are queued
        ird_pct = 0;
        lat_min = 2;
        lat_max = 2;
        do_reset();
        wait_cyc(4);
        redir_req = 1;
        redir_target = 32'h0000_2000;
        ird_pct = 100;
        d0 = deliv_cnt;
        wait_cyc(20);
        chk("redirect_rsp_pop_progress", 32'(deliv_cnt - d0 >= 5), 32'd1);

        // address wrap
        lat_min = 1;
        lat_max = 1;
        redir_req = 1;
        redir_target = 32'hFFFF_FFF7;
        wait_cyc(15);
        chk("wrap_seen", 32'(saw_wrap), 32'd1);

        // random ready, latency and redirects
        rdy_pct = 60;
        ird_pct = 70;
        lat_min = 1;
        lat_max = 5;
        d0 = deliv_cnt;
        n = 0;
        while (deliv_cnt - d0 < 1000 && n < 30000) begin
            wait_cyc(1);
            n++;
            if ($urandom_range(99) < 3) begin
                redir_req = 1;
                redir_target = $urandom();
            end
        end
        chk("random_delivered_1000", 32'(deliv_cnt - d0 >= 1000), 32'd1);

        // drain: every accepted live fetch must reach decode
        rdy_pct = 0;
        ird_pct = 100;
        n = 0;
        while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 200) begin
            wait_cyc(1);
            n++;
        end
        chk("drain_complete", 32'(exp_q.size()), 32'd0);
        wait_cyc(2);
        chk("idle_busy", 32'(busy), 32'd0);

        // asynchronous reset mid-stream
        rdy_pct = 100;
        ird_pct = 50;
        lat_min = 1;
        lat_max = 3;
        wait_cyc(10);
        chk("busy_before_reset", 32'(busy), 32'd1);
        reset = 1;
        #1;
        chk("midreset_req_valid", 32'(imem_req_valid), 32'd0);
        chk("midreset_req_addr", imem_req_addr, 32'h0);
        chk("midreset_inst_valid", 32'(inst_valid), 32'd0);
        chk("midreset_inst_code", inst_code, 32'h0);
        chk("midreset_inst_pc", inst_pc, 32'h0);
        chk("midreset_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clock);
        #4 reset = 0;
        wait_cyc(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
